// File: rtl/ebpf_alu.sv
// 64-bit eBPF execution unit: operand muxes, ALU64/ALU32/JMP/address ops, registered z/cmp.
// Define EBPF_ALU_MULDIV_EN to build MUL/DIV/MOD; otherwise those ops return zero.
module ebpf_alu (
    input  logic        clock,
    input  logic        nrst,
    input  logic [63:0] src_in,
    input  logic [63:0] dst_in,
    input  logic [63:0] imm,
    input  logic [63:0] off,
    input  logic        x_sel,
    input  logic [1:0]  y_sel,
    input  logic [7:0]  op,
    output logic [63:0] z,
    output logic        cmp
);

    localparam logic [2:0] CLS_LD    = 3'd0;
    localparam logic [2:0] CLS_LDX   = 3'd1;
    localparam logic [2:0] CLS_ST    = 3'd2;
    localparam logic [2:0] CLS_STX   = 3'd3;
    localparam logic [2:0] CLS_ALU   = 3'd4;
    localparam logic [2:0] CLS_JMP   = 3'd5;
    localparam logic [2:0] CLS_ALU64 = 3'd7;

    logic [63:0] x;
    logic [63:0] y;
    logic [2:0]  op_class;
    logic [3:0]  code;
    logic [63:0] alu64_res;
    logic [31:0] alu32_res;
    logic        jmp_res;
    logic [63:0] z_d, z_q;
    logic        cmp_d, cmp_q;

    // K/X source bit is redundant here: the decoder steers operands via x_sel/y_sel.
    logic unused_op_kx;
    assign unused_op_kx = op[3];

    assign op_class = op[2:0];
    assign code     = op[7:4];

    always_comb begin
        x = x_sel ? src_in : dst_in;
        case (y_sel)
            2'b00:   y = src_in;
            2'b01:   y = imm;
            2'b10:   y = off;
            default: y = 64'd0;
        endcase
    end

    always_comb begin
        alu64_res = 64'd0;
        case (code)
            4'h0: alu64_res = x + y;
            4'h1: alu64_res = x - y;
`ifdef EBPF_ALU_MULDIV_EN
            4'h2: alu64_res = x * y;
            4'h3: alu64_res = (y == 64'd0) ? 64'd0 : x / y;
            4'h9: alu64_res = (y == 64'd0) ? x : x % y;
`else
            4'h2: alu64_res = 64'd0;
            4'h3: alu64_res = 64'd0;
            4'h9: alu64_res = 64'd0;
`endif
            4'h4: alu64_res = x | y;
            4'h5: alu64_res = x & y;
            4'h6: alu64_res = x << y[5:0];
            4'h7: alu64_res = x >> y[5:0];
            4'h8: alu64_res = 64'd0 - x;
            4'hA: alu64_res = x ^ y;
            4'hB: alu64_res = y;
            4'hC: alu64_res = $unsigned($signed(x) >>> y[5:0]);
            default: alu64_res = 64'd0;
        endcase
    end

    logic [31:0] x32;
    logic [31:0] y32;
    assign x32 = x[31:0];
    assign y32 = y[31:0];

    always_comb begin
        alu32_res = 32'd0;
        case (code)
            4'h0: alu32_res = x32 + y32;
            4'h1: alu32_res = x32 - y32;
`ifdef EBPF_ALU_MULDIV_EN
            4'h2: alu32_res = x32 * y32;
            4'h3: alu32_res = (y32 == 32'd0) ? 32'd0 : x32 / y32;
            4'h9: alu32_res = (y32 == 32'd0) ? x32 : x32 % y32;
`else
            4'h2: alu32_res = 32'd0;
            4'h3: alu32_res = 32'd0;
            4'h9: alu32_res = 32'd0;
`endif
            4'h4: alu32_res = x32 | y32;
            4'h5: alu32_res = x32 & y32;
            4'h6: alu32_res = x32 << y32[4:0];
            4'h7: alu32_res = x32 >> y32[4:0];
            4'h8: alu32_res = 32'd0 - x32;
            4'hA: alu32_res = x32 ^ y32;
            4'hB: alu32_res = y32;
            4'hC: alu32_res = $unsigned($signed(x32) >>> y32[4:0]);
            default: alu32_res = 32'd0;
        endcase
    end

    always_comb begin
        jmp_res = 1'b0;
        case (code)
            4'h0: jmp_res = 1'b1;
            4'h1: jmp_res = (x == y);
            4'h2: jmp_res = (x > y);
            4'h3: jmp_res = (x >= y);
            4'h4: jmp_res = ((x & y) != 64'd0);
            4'h5: jmp_res = (x != y);
            4'h6: jmp_res = ($signed(x) > $signed(y));
            4'h7: jmp_res = ($signed(x) >= $signed(y));
            default: jmp_res = 1'b0;
        endcase
    end

    always_comb begin
        z_d   = 64'd0;
        cmp_d = 1'b0;
        case (op_class)
            CLS_LD, CLS_LDX, CLS_ST, CLS_STX: z_d = x + y;
            CLS_ALU:   z_d = {32'd0, alu32_res};
            CLS_ALU64: z_d = alu64_res;
            CLS_JMP:   cmp_d = jmp_res;
            default: begin
                z_d   = 64'd0;
                cmp_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            z_q   <= 64'd0;
            cmp_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            cmp_q <= cmp_d;
        end
    end

    assign z   = z_q;
    assign cmp = cmp_q;

endmodule

// File: tb/tb_ebpf_alu.sv
// Directed bench for ebpf_alu: hand-computed vectors, one result per clock edge.
module tb_ebpf_alu;

    logic        clock = 1'b0;
    logic        nrst;
    logic [63:0] src_in, dst_in, imm, off;
    logic        x_sel;
    logic [1:0]  y_sel;
    logic [7:0]  op;
    logic [63:0] z;
    logic        cmp;

    int checks = 0;
    int errors = 0;

    ebpf_alu dut (
        .clock (clock),
        .nrst  (nrst),
        .src_in(src_in),
        .dst_in(dst_in),
        .imm   (imm),
        .off   (off),
        .x_sel (x_sel),
        .y_sel (y_sel),
        .op    (op),
        .z     (z),
        .cmp   (cmp)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] z_exp, input logic cmp_exp);
        checks++;
        assert (z === z_exp) else begin
            errors++;
            $error("FAIL %s z observed=%h expected=%h", tag, z, z_exp);
        end
        checks++;
        assert (cmp === cmp_exp) else begin
            errors++;
            $error("FAIL %s cmp observed=%b expected=%b", tag, cmp, cmp_exp);
        end
    endtask

    task automatic apply(input logic [7:0] o, input logic xs, input logic [1:0] ys,
                         input logic [63:0] d, input logic [63:0] s,
                         input logic [63:0] i, input logic [63:0] f);
        op = o; x_sel = xs; y_sel = ys;
        dst_in = d; src_in = s; imm = i; off = f;
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [7:0] o, input logic xs,
                        input logic [1:0] ys, input logic [63:0] d, input logic [63:0] s,
                        input logic [63:0] i, input logic [63:0] f,
                        input logic [63:0] z_exp, input logic cmp_exp);
        apply(o, xs, ys, d, s, i, f);
        check(tag, z_exp, cmp_exp);
    endtask

    initial begin
        nrst = 1'b0;
        op = 8'h07; x_sel = 1'b0; y_sel = 2'b01;
        dst_in = 64'd5; src_in = 64'd0; imm = 64'd3; off = 64'd0;
        @(posedge clock); #1;
        check("reset_edge1", 64'd0, 1'b0);
        @(posedge clock); #1;
        check("reset_edge2", 64'd0, 1'b0);
        nrst = 1'b1;
        check("release_hold", 64'd0, 1'b0);
        @(posedge clock); #1;
        check("release_first", 64'd8, 1'b0);

        step("sub64", 8'h1F, 0, 2'b00, 64'd5, 64'd7, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        step("add32_wrap", 8'h04, 0, 2'b01, 64'h1_FFFF_FFFF, 0, 64'd1, 0, 64'd0, 0);
        step("arsh32", 8'hC4, 0, 2'b01, 64'h8000_0000, 0, 64'd4, 0, 64'h0000_0000_F800_0000, 0);
        step("lsh64_mask", 8'h67, 0, 2'b01, 64'd1, 0, 64'd65, 0, 64'd2, 0);
        step("arsh64", 8'hC7, 0, 2'b01, 64'h8000_0000_0000_0000, 0, 64'd63, 0, '1, 0);
        step("rsh64", 8'h77, 0, 2'b01, 64'h8000_0000_0000_0000, 0, 64'd63, 0, 64'd1, 0);
        step("lsh32_mask", 8'h64, 0, 2'b01, 64'hFFFF_FFFF_0000_0001, 0, 64'd33, 0, 64'd2, 0);
        step("or64", 8'h4F, 1, 2'b01, 0, 64'hF0, 64'h0F, 0, 64'hFF, 0);
        step("and64", 8'h5F, 0, 2'b00, 64'hFF00, 64'h0FF0, 0, 0, 64'h0F00, 0);
        step("xor64", 8'hA7, 0, 2'b01, 64'hAAAA, 0, 64'hFFFF, 0, 64'h5555, 0);
        step("mov64", 8'hB7, 0, 2'b01, 64'd99, 0, 64'h1234, 0, 64'h1234, 0);
        step("mov_zero", 8'hB7, 0, 2'b11, 64'd99, 64'd7, 64'd8, 64'd9, 64'd0, 0);
        step("neg64", 8'h87, 0, 2'b01, 64'd1, 0, 0, 0, '1, 0);
        step("neg32", 8'h84, 0, 2'b01, 64'd1, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 0);
        step("code_d", 8'hD7, 0, 2'b01, 64'd5, 0, 64'd3, 0, 64'd0, 0);
        step("class6", 8'h06, 0, 2'b01, 64'd5, 0, 64'd3, 0, 64'd0, 0);

`ifdef EBPF_ALU_MULDIV_EN
        step("div_zero", 8'h3F, 0, 2'b00, 64'd9, 64'd0, 0, 0, 64'd0, 0);
        step("mod_zero", 8'h9F, 0, 2'b00, 64'd9, 64'd0, 0, 0, 64'd9, 0);
        step("div", 8'h3F, 0, 2'b00, 64'd9, 64'd2, 0, 0, 64'd4, 0);
        step("mul", 8'h2F, 0, 2'b00, 64'd3, 64'd4, 0, 0, 64'd12, 0);
        step("mod32", 8'h9C, 0, 2'b00, 64'h5_0000_0007, 64'd4, 0, 0, 64'd3, 0);
`else
        step("div_zero", 8'h3F, 0, 2'b00, 64'd9, 64'd0, 0, 0, 64'd0, 0);
        step("mod_off", 8'h9F, 0, 2'b00, 64'd9, 64'd0, 0, 0, 64'd0, 0);
        step("div_off", 8'h3F, 0, 2'b00, 64'd9, 64'd2, 0, 0, 64'd0, 0);
        step("mul_off", 8'h2F, 0, 2'b00, 64'd3, 64'd4, 0, 0, 64'd0, 0);
        step("mul32_off", 8'h2C, 0, 2'b00, 64'd3, 64'd4, 0, 0, 64'd0, 0);
`endif

        step("jeq", 8'h15, 0, 2'b01, 64'd4, 0, 64'd4, 0, 64'd0, 1);
        step("jeq_ne", 8'h15, 0, 2'b01, 64'd4, 0, 64'd5, 0, 64'd0, 0);
        step("jgt", 8'h25, 0, 2'b01, '1, 0, 64'd1, 0, 64'd0, 1);
        step("jsgt", 8'h65, 0, 2'b01, '1, 0, 64'd1, 0, 64'd0, 0);
        step("jge_eq", 8'h35, 0, 2'b01, 64'd7, 0, 64'd7, 0, 64'd0, 1);
        step("jset", 8'h45, 0, 2'b01, 64'h10, 0, 64'h30, 0, 64'd0, 1);
        step("jset_none", 8'h45, 0, 2'b01, 64'h10, 0, 64'h20, 0, 64'd0, 0);
        step("jne", 8'h5D, 0, 2'b00, 64'd1, 64'd2, 0, 0, 64'd0, 1);
        step("jsge_eq", 8'h75, 0, 2'b01, '1, 0, '1, 0, 64'd0, 1);
        step("jsge_lt", 8'h75, 0, 2'b01, '1, 0, 64'd0, 0, 64'd0, 0);
        step("ja", 8'h05, 0, 2'b11, 0, 0, 0, 0, 64'd0, 1);
        step("exit", 8'h95, 0, 2'b01, 64'd4, 0, 64'd4, 0, 64'd0, 0);
        step("call", 8'h85, 0, 2'b01, 64'd4, 0, 64'd4, 0, 64'd0, 0);
        step("ldx_addr", 8'h79, 1, 2'b10, 0, 64'h100, 0, 64'd8, 64'h108, 0);
        step("stx_addr", 8'h63, 0, 2'b10, 64'h200, 0, 0, '1, 64'h1FF, 0);

        // Load a taken branch, then reset mid-stream to confirm it clears both outputs.
        step("pre_reset", 8'h15, 0, 2'b01, 64'd4, 0, 64'd4, 0, 64'd0, 1);
        step("pre_reset_z", 8'h07, 0, 2'b01, 64'd5, 0, 64'd3, 0, 64'd8, 0);
        nrst = 1'b0;
        op = 8'h15; dst_in = 64'd4; imm = 64'd4;
        @(posedge clock); #1;
        check("mid_reset", 64'd0, 1'b0);
        nrst = 1'b1;
        @(posedge clock); #1;
        check("post_reset", 64'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
